quant_multi: RTL and testbench

Parametrised JPEG quantizer for the camera JPEG encoder. It sits between the 2-D DCT output and the zigzag/entropy stage. It takes `LANES` signed DCT coefficients per beat in zigzag order, multiplies each by a runtime-loadable reciprocal quantization factor, then rounds and saturates the result. Alongside each beat it emits block component (Y/Cb/Cr), beat count and last-MCU tags, for 4:2:0, 4:2:2, 4:4:4 and grayscale MCU layouts.

---
 rtl/quant_multi_pkg.sv | 60 ++++++
 rtl/quant_multi_if.sv | 30 +++
 rtl/quant_table_ram.sv | 39 +++
 rtl/quant_multi.sv | 160 ++++++++++++++++
 tb/tb_quant_multi.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/quant_multi_pkg.sv
// rtl/quant_multi_pkg.sv - shared types and lookup helpers for the JPEG quantizer
package quant_multi_pkg;

  typedef enum logic [1:0] {
    SS_420  = 2'd0,
    SS_422  = 2'd1,
    SS_444  = 2'd2,
    SS_GRAY = 2'd3
  } ss_mode_e;

  typedef enum logic [1:0] {
    COMP_Y  = 2'd0,
    COMP_CB = 2'd1,
    COMP_CR = 2'd2
  } comp_e;

  function automatic logic [2:0] blocks_per_mcu(input ss_mode_e m);
    case (m)
      SS_420:  return 3'd6;
      SS_422:  return 3'd4;
      SS_444:  return 3'd3;
      default: return 3'd1;
    endcase
  endfunction

  function automatic logic [2:0] mcu_w_log2(input ss_mode_e m);
    case (m)
      SS_420, SS_422: return 3'd4;
      default:        return 3'd3;
    endcase
  endfunction

  function automatic logic [2:0] mcu_h_log2(input ss_mode_e m);
    case (m)
      SS_420:  return 3'd4;
      default: return 3'd3;
    endcase
  endfunction

  // Chroma blocks are always the last two of an MCU; everything before them is luma.
  function automatic comp_e comp_of(input ss_mode_e m, input logic [2:0] blk);
    logic [2:0] n;
    n = blocks_per_mcu(m);
    if (m == SS_GRAY) return COMP_Y;
    if (blk == n - 3'd1) return COMP_CR;
    if (blk == n - 3'd2) return COMP_CB;
    return COMP_Y;
  endfunction

  function automatic logic signed [31:0] sat_q(input logic signed [63:0] v, input int qw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (qw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (qw - 1));
    if (v > hi) return 32'(hi);
    if (v < lo) return 32'(lo);
    return 32'(v);
  endfunction

endpackage

// File: rtl/quant_multi_if.sv
// rtl/quant_multi_if.sv - coefficient in / quantized out stream bundle
interface quant_multi_if #(
  parameter int DW    = 15,
  parameter int QW    = 11,
  parameter int LANES = 2,
  localparam int CW   = $clog2(64 / LANES)
) ();

  logic [LANES-1:0][DW-1:0] di;
  logic                     di_valid;
  logic                     di_hold;
  logic [CW-1:0]            di_cnt;
  logic [LANES-1:0][QW-1:0] q;
  logic                     q_valid;
  logic                     q_hold;
  logic [CW-1:0]            q_cnt;
  logic [1:0]               q_chroma;
  logic                     q_last_mcu;

  modport master (
    output di, di_valid, di_cnt, q_hold,
    input  di_hold, q, q_valid, q_cnt, q_chroma, q_last_mcu
  );

  modport slave (
    input  di, di_valid, di_cnt, q_hold,
    output di_hold, q, q_valid, q_cnt, q_chroma, q_last_mcu
  );

endinterface

// File: rtl/quant_table_ram.sv
// rtl/quant_table_ram.sv - banked reciprocal table, one write port, LANES registered reads
module quant_table_ram #(
  parameter int LANES  = 2,
  parameter int M_BITS = 13,
  parameter int CW     = 5
) (
  input  logic                         clk,
  input  logic                         tw_en,
  input  logic [6:0]                   tw_addr,
  input  logic [M_BITS-1:0]            tw_data,
  input  logic                         rd_en,
  input  logic [CW:0]                  rd_addr,
  output logic [LANES-1:0][M_BITS-1:0] rd_data
);

  localparam int DEPTH = 2 << CW;

  logic [5:0] w_idx;
  logic [CW:0] w_word;

  assign w_idx  = tw_addr[5:0];
  assign w_word = {tw_addr[6], CW'(w_idx / 6'(LANES))};

  // Lane i of a beat always maps to bank i, so every bank reads the same word address.
  for (genvar b = 0; b < LANES; b++) begin : g_bank
    logic [M_BITS-1:0] mem [DEPTH];
    logic [M_BITS-1:0] rd_q;
    logic              w_hit;

    assign w_hit      = tw_en && ((w_idx % 6'(LANES)) == 6'(b));
    assign rd_data[b] = rd_q;

    always_ff @(posedge clk) begin
      if (w_hit) mem[w_word] <= tw_data;
      if (rd_en) rd_q <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/quant_multi.sv
// rtl/quant_multi.sv - two-stage reciprocal quantizer with MCU component / last-block tagging
module quant_multi
  import quant_multi_pkg::*;
#(
  parameter int DW            = 15,
  parameter int QW            = 11,
  parameter int M_BITS        = 13,
  parameter int LANES         = 2,
  parameter int SENSOR_X_SIZE = 1280,
  parameter int SENSOR_Y_SIZE = 720,
  localparam int BEATS        = 64 / LANES,
  localparam int CW           = $clog2(BEATS),
  localparam int XW           = $clog2(SENSOR_X_SIZE),
  localparam int YW           = $clog2(SENSOR_Y_SIZE)
) (
  input  logic              clk,
  input  logic              resetn,
  quant_multi_if.slave      bus,
  input  logic [XW-1:0]     x_size_m1,
  input  logic [YW-1:0]     y_size_m1,
  input  logic [1:0]        ss_mode,
  input  logic              tw_en,
  input  logic [6:0]        tw_addr,
  input  logic [M_BITS-1:0] tw_data
);

  localparam int PW = DW + M_BITS + 1;
  localparam logic signed [PW-1:0] RND = PW'(2 ** (M_BITS - 2));

  logic accept;
  assign accept      = bus.di_valid & ~bus.q_hold;
  assign bus.di_hold = bus.q_hold;

  logic [2:0]    blk_cnt, blk_nx, n_blk;
  logic [XW-1:0] x_mcu, x_nx, x_max, cfg_x, eff_x;
  logic [YW-1:0] y_mcu, y_nx, y_max, cfg_y, eff_y;
  ss_mode_e      cfg_mode, eff_mode;
  comp_e         comp;
  logic          frame_start, blk_last, mcu_last;

  // The first beat of a frame sees the live configuration; later beats see the latched copy.
  assign frame_start = (blk_cnt == 3'd0) && (x_mcu == '0) && (y_mcu == '0) && (bus.di_cnt == '0);

  always_comb begin
    eff_mode = frame_start ? ss_mode_e'(ss_mode) : cfg_mode;
    eff_x    = frame_start ? x_size_m1 : cfg_x;
    eff_y    = frame_start ? y_size_m1 : cfg_y;
    n_blk    = blocks_per_mcu(eff_mode);
    x_max    = eff_x >> mcu_w_log2(eff_mode);
    y_max    = eff_y >> mcu_h_log2(eff_mode);
    blk_last = (blk_cnt == n_blk - 3'd1);
    mcu_last = (x_mcu == x_max) && (y_mcu == y_max);
    comp     = comp_of(eff_mode, blk_cnt);
    blk_nx   = blk_cnt;
    x_nx     = x_mcu;
    y_nx     = y_mcu;
    if (bus.di_cnt == CW'(BEATS - 1)) begin
      if (blk_last) begin
        blk_nx = 3'd0;
        if (x_mcu == x_max) begin
          x_nx = '0;
          y_nx = (y_mcu == y_max) ? '0 : y_mcu + 1'b1;
        end else begin
          x_nx = x_mcu + 1'b1;
        end
      end else begin
        blk_nx = blk_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blk_cnt  <= 3'd0;
      x_mcu    <= '0;
      y_mcu    <= '0;
      cfg_mode <= SS_420;
      cfg_x    <= '0;
      cfg_y    <= '0;
    end else if (accept) begin
      blk_cnt <= blk_nx;
      x_mcu   <= x_nx;
      y_mcu   <= y_nx;
      if (frame_start) begin
        cfg_mode <= ss_mode_e'(ss_mode);
        cfg_x    <= x_size_m1;
        cfg_y    <= y_size_m1;
      end
    end
  end

  logic [LANES-1:0][M_BITS-1:0] f_rd;

  quant_table_ram #(
    .LANES  (LANES),
    .M_BITS (M_BITS),
    .CW     (CW)
  ) u_ram (
    .clk     (clk),
    .tw_en   (tw_en),
    .tw_addr (tw_addr),
    .tw_data (tw_data),
    .rd_en   (accept),
    .rd_addr ({comp != COMP_Y, bus.di_cnt}),
    .rd_data (f_rd)
  );

  logic [LANES-1:0][DW-1:0] di_r;
  logic [CW-1:0]            cnt_r;
  logic [1:0]               chroma_r;
  logic                     last_r;
  logic                     valid_r;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      di_r     <= '0;
      cnt_r    <= '0;
      chroma_r <= 2'd0;
      last_r   <= 1'b0;
      valid_r  <= 1'b0;
    end else if (!bus.q_hold) begin
      valid_r <= bus.di_valid;
      if (accept) begin
        di_r     <= bus.di;
        cnt_r    <= bus.di_cnt;
        chroma_r <= comp;
        last_r   <= blk_last && mcu_last;
      end
    end
  end

  logic [LANES-1:0][QW-1:0] q_lane;

  // Full-width signed product keeps the round-half-up offset exact before the arithmetic shift.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [PW-1:0] a, b, p, s;
    assign a         = PW'($signed(di_r[i]));
    assign b         = PW'(f_rd[i]);
    assign p         = a * b + RND;
    assign s         = p >>> (M_BITS - 1);
    assign q_lane[i] = QW'(sat_q(64'(s), QW));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.q          <= '0;
      bus.q_valid    <= 1'b0;
      bus.q_cnt      <= '0;
      bus.q_chroma   <= 2'd0;
      bus.q_last_mcu <= 1'b0;
    end else if (!bus.q_hold) begin
      bus.q          <= q_lane;
      bus.q_valid    <= valid_r;
      bus.q_cnt      <= cnt_r;
      bus.q_chroma   <= chroma_r;
      bus.q_last_mcu <= last_r;
    end
  end

endmodule

// File: tb/tb_quant_multi.sv
// tb/tb_quant_multi.sv - directed vector bench for quant_multi
module tb_quant_multi;

  localparam int DW     = 15;
  localparam int QW     = 11;
  localparam int M_BITS = 13;
  localparam int LANES  = 2;
  localparam int BEATS  = 32;
  localparam int CW     = 5;
  localparam int NV     = 12;

  localparam logic [11:0] SEQ420 = {2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
  localparam logic [11:0] SEQ422 = {4'd0, 2'd2, 2'd1, 2'd0, 2'd0};
  localparam logic [11:0] SEQ444 = {6'd0, 2'd2, 2'd1, 2'd0};

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [10:0]       x_size_m1;
  logic [9:0]        y_size_m1;
  logic [1:0]        ss_mode;
  logic              tw_en;
  logic [6:0]        tw_addr;
  logic [M_BITS-1:0] tw_data;

  quant_multi_if #(.DW(DW), .QW(QW), .LANES(LANES)) bus ();

  quant_multi #(
    .DW            (DW),
    .QW            (QW),
    .M_BITS        (M_BITS),
    .LANES         (LANES),
    .SENSOR_X_SIZE (1280),
    .SENSOR_Y_SIZE (720)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .x_size_m1 (x_size_m1),
    .y_size_m1 (y_size_m1),
    .ss_mode   (ss_mode),
    .tw_en     (tw_en),
    .tw_addr   (tw_addr),
    .tw_data   (tw_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d0;
    int d1;
    int f;
    int e0;
    int e1;
  } vec_t;

  typedef struct {
    int q0;
    int q1;
    int cnt;
    int chroma;
    bit last;
  } exp_t;

  vec_t vt [NV];
  exp_t exp_q [$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (bus.q_valid && !bus.q_hold) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_beat: got beat cnt=%0d, expected no beat", bus.q_cnt);
      end else begin
        e = exp_q.pop_front();
        if (int'($signed(bus.q[0])) != e.q0 || int'($signed(bus.q[1])) != e.q1 ||
            int'(bus.q_cnt) != e.cnt || int'(bus.q_chroma) != e.chroma || bus.q_last_mcu != e.last) begin
          n_bad++;
          $display("FAIL beat: got q={%0d,%0d} cnt=%0d chroma=%0d last=%0d, expected q={%0d,%0d} cnt=%0d chroma=%0d last=%0d",
                   $signed(bus.q[0]), $signed(bus.q[1]), bus.q_cnt, bus.q_chroma, bus.q_last_mcu,
                   e.q0, e.q1, e.cnt, e.chroma, e.last);
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic write_tbl(input int a, input int d);
    tw_en   = 1'b1;
    tw_addr = 7'(a);
    tw_data = M_BITS'(d);
    @(posedge clk);
    #1;
    tw_en = 1'b0;
  endtask

  task automatic drain();
    bus.di_valid = 1'b0;
    repeat (4) cycle();
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic hold_cycles();
    logic [LANES*QW-1:0] sq;
    logic                sv;
    bus.q_hold = 1'b1;
    @(negedge clk);
    sq = bus.q;
    sv = bus.q_valid;
    check("hold_valid", int'(sv), 1);
    check("hold_di_hold", int'(bus.di_hold), 1);
    for (int i = 1; i < 3; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("hold_q_frozen", int'(bus.q), int'(sq));
      check("hold_valid_frozen", int'(bus.q_valid), int'(sv));
    end
    @(posedge clk);
    #1;
    bus.q_hold = 1'b0;
  endtask

  task automatic send(input int d0, input int d1, input int k, input exp_t e);
    bus.di[0]    = DW'(d0);
    bus.di[1]    = DW'(d1);
    bus.di_cnt   = CW'(k);
    bus.di_valid = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic run_frame(input logic [1:0] mode, input int nblk, input int bpm,
                           input logic [11:0] seq, input int stall_at, input bit vary);
    exp_t e;
    int   d0;
    ss_mode = mode;
    for (int b = 0; b < nblk; b++) begin
      for (int k = 0; k < BEATS; k++) begin
        d0       = vary ? 20 * b + k : 100;
        e.q0     = d0;
        e.q1     = -d0;
        e.cnt    = k;
        e.chroma = int'(seq[2*(b%bpm) +: 2]);
        e.last   = (b == nblk - 1);
        send(d0, -d0, k, e);
        if (b * BEATS + k == stall_at) hold_cycles();
        cycle();
      end
    end
    drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    exp_t e;
    vt[0]  = '{3, -3, 2048, 2, -1};
    vt[1]  = '{1, -1, 2048, 1, 0};
    vt[2]  = '{16383, -16384, 4096, 1023, -1024};
    vt[3]  = '{100, -100, 4096, 100, -100};
    vt[4]  = '{0, 0, 4096, 0, 0};
    vt[5]  = '{1000, -1000, 8191, 1023, -1024};
    vt[6]  = '{500, -500, 1024, 125, -125};
    vt[7]  = '{1023, -1024, 4096, 1023, -1024};
    vt[8]  = '{1024, -1025, 4096, 1023, -1024};
    vt[9]  = '{7, -7, 6144, 11, -10};
    vt[10] = '{0, 5, 0, 0, 0};
    vt[11] = '{-2, 2, 2048, -1, 1};

    bus.di       = '0;
    bus.di_valid = 1'b0;
    bus.di_cnt   = '0;
    bus.q_hold   = 1'b0;
    tw_en        = 1'b0;
    tw_addr      = '0;
    tw_data      = '0;
    ss_mode      = 2'd3;
    x_size_m1    = 11'd7;
    y_size_m1    = 10'd7;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_q_valid", int'(bus.q_valid), 0);
    check("rst_q", int'(bus.q), 0);
    check("rst_q_cnt", int'(bus.q_cnt), 0);
    check("rst_q_chroma", int'(bus.q_chroma), 0);
    check("rst_q_last_mcu", int'(bus.q_last_mcu), 0);
    bus.q_hold = 1'b1;
    #1;
    check("di_hold_high", int'(bus.di_hold), 1);
    bus.q_hold = 1'b0;
    #1;
    check("di_hold_low", int'(bus.di_hold), 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    for (int k = 0; k < BEATS; k++) begin
      write_tbl(2 * k, (k < NV) ? vt[k].f : 0);
      write_tbl(2 * k + 1, (k < NV) ? vt[k].f : 0);
    end
    for (int k = 0; k < BEATS; k++) begin
      e.q0     = (k < NV) ? vt[k].e0 : 0;
      e.q1     = (k < NV) ? vt[k].e1 : 0;
      e.cnt    = k;
      e.chroma = 0;
      e.last   = 1'b1;
      send((k < NV) ? vt[k].d0 : 0, (k < NV) ? vt[k].d1 : 0, k, e);
      cycle();
    end
    drain();

    x_size_m1 = 11'd31;
    y_size_m1 = 10'd15;
    for (int a = 0; a < 128; a++) write_tbl(a, 4096);

    run_frame(2'd0, 12, 6, SEQ420, BEATS + 10, 1'b1);
    run_frame(2'd2, 24, 3, SEQ444, -1, 1'b0);
    run_frame(2'd3, 8, 1, 12'd0, -1, 1'b1);

    ss_mode = 2'd0;
    for (int i = 0; i < 3 * BEATS + 7; i++) begin
      e.q0     = 50;
      e.q1     = -50;
      e.cnt    = i % BEATS;
      e.chroma = 0;
      e.last   = 1'b0;
      send(50, -50, i % BEATS, e);
      cycle();
    end
    check("pre_reset_valid", int'(bus.q_valid), 1);
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset_valid", int'(bus.q_valid), 0);
    check("async_reset_cnt", int'(bus.q_cnt), 0);
    bus.di_valid = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cycle();
    run_frame(2'd1, 16, 4, SEQ422, -1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
